// File: rtl/float_divider.sv
// Sequential floating-point divider (bf16 by default): restoring mantissa division,
// one quotient bit per cycle, round-to-nearest-even, subnormals flushed to zero.
module float_divider #(
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 7
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [EXP_BITS+MANT_BITS:0] a,
  input  logic [EXP_BITS+MANT_BITS:0] b,
  input  logic                        start,
  output logic [EXP_BITS+MANT_BITS:0] y,
  output logic                        is_output_valid,
  output logic                        busy
);
  localparam int W  = 1 + EXP_BITS + MANT_BITS;
  localparam int EW = EXP_BITS + 2;
  localparam int QW = MANT_BITS + 3;
  localparam int CW = $clog2(QW) + 1;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_BITS-1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_BITS) - 1);
  localparam logic signed [EW-1:0] ONE  = EW'(1);

  typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, ROUND, DONE} state_t;
  state_t r_state, w_next;

  logic [W-1:0]            r_a, r_b, r_y;
  logic                    r_sign, r_nan, r_inf, r_zero, r_valid, r_busy;
  logic signed [EW-1:0]    r_exp;
  logic [MANT_BITS:0]      r_mb;
  logic [MANT_BITS+1:0]    r_rem;
  logic [QW-1:0]           r_quo;
  logic [CW-1:0]           r_cnt;

  logic [EXP_BITS-1:0]     w_ea, w_eb;
  logic                    w_a_zero, w_b_zero, w_accept, w_ge;
  logic [MANT_BITS+1:0]    w_diff;

  assign w_ea     = r_a[W-2:MANT_BITS];
  assign w_eb     = r_b[W-2:MANT_BITS];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_ge     = (r_rem >= {1'b0, r_mb});
  assign w_diff   = r_rem - {1'b0, r_mb};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_next = LOAD;
      LOAD:       w_next = DIVIDE;
      DIVIDE:     if (r_cnt == CW'(QW-1)) w_next = ROUND;
      ROUND:      w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  // Normalize, round and resolve specials from the finished quotient.
  logic [MANT_BITS-1:0]  w_mant;
  logic                  w_guard, w_rbit, w_sticky, w_up, w_carry;
  logic [MANT_BITS:0]    w_mant_r;
  logic signed [EW-1:0]  w_e0, w_e1;
  logic [W-1:0]          w_y;

  always_comb begin
    w_sticky = (r_rem != '0);
    if (r_quo[QW-1]) begin
      w_mant  = r_quo[QW-2:2];
      w_guard = r_quo[1];
      w_rbit  = r_quo[0];
      w_e0    = r_exp;
    end else begin
      w_mant  = r_quo[QW-3:1];
      w_guard = r_quo[0];
      w_rbit  = 1'b0;
      w_e0    = r_exp - ONE;
    end
    w_up     = w_guard && (w_rbit || w_sticky || w_mant[0]);
    w_mant_r = {1'b0, w_mant} + (MANT_BITS+1)'(w_up);
    w_carry  = w_mant_r[MANT_BITS];
    w_e1     = w_e0 + (w_carry ? ONE : '0);
    if (r_nan)
      w_y = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};
    else if (r_inf || (!r_zero && w_e1 >= EMAX))
      w_y = {r_sign, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
    else if (r_zero || w_e1[EW-1] || w_e1 == '0)
      w_y = {r_sign, {(W-1){1'b0}}};
    else
      w_y = {r_sign, w_e1[EXP_BITS-1:0], w_carry ? {MANT_BITS{1'b0}} : w_mant_r[MANT_BITS-1:0]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a <= '0; r_b <= '0; r_y <= '0;
      r_sign <= 1'b0; r_nan <= 1'b0; r_inf <= 1'b0; r_zero <= 1'b0;
      r_valid <= 1'b0; r_busy <= 1'b0;
      r_exp <= '0; r_mb <= '0; r_rem <= '0; r_quo <= '0; r_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_valid <= 1'b0;
        r_busy  <= 1'b1;
      end
      case (r_state)
        LOAD: begin
          r_sign <= r_a[W-1] ^ r_b[W-1];
          r_exp  <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + BIAS;
          r_rem  <= {1'b0, ~w_a_zero, r_a[MANT_BITS-1:0]};
          r_mb   <= {1'b1, r_b[MANT_BITS-1:0]};
          r_nan  <= (&w_ea) || (&w_eb) || (w_a_zero && w_b_zero);
          r_inf  <= w_b_zero;
          r_zero <= w_a_zero;
          r_quo  <= '0;
          r_cnt  <= '0;
        end
        DIVIDE: begin
          r_rem <= (w_ge ? w_diff : r_rem) << 1;
          r_quo <= {r_quo[QW-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        ROUND: begin
          r_y     <= w_y;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign y               = r_y;
  assign is_output_valid = r_valid;
  assign busy            = r_busy;
endmodule
